// File: rtl/alu32_ctrl.sv
// Register-mapped sequencer in front of alu32: operand/opcode registers, EXEC/CLR
// handshake with feedback capture, and a result FIFO read through a slave port.
module alu32_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [2:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        o_irq,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  opcode,
    output logic        op_start,
    output logic        op_clear,
    output logic [1:0]  op_done_before,
    output logic [31:0] result1_before,
    output logic [31:0] result2_before,
    input  logic [1:0]  alu_op_done,
    input  logic [31:0] alu_result1,
    input  logic [31:0] alu_result2
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLR} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]   r_a, r_b, r_dout;
    logic [3:0]    r_opcode;
    logic          r_int_en, r_err_op, r_aborted, r_start_rej;
    logic [1:0]    r_done_fb;
    logic [31:0]   r_res1_fb, r_res2_fb;
    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;

    logic        w_wr, w_rd, w_start, w_abort, w_w1c, w_busy, w_full, w_empty;
    logic        w_push, w_pop, w_set_err, w_set_abort, w_set_rej;
    logic [3:0]  w_count4;
    logic [63:0] w_head;
    logic [31:0] w_rdata;

    assign w_wr     = s_sel & s_wr;
    assign w_rd     = s_sel & ~s_wr;
    assign w_start  = w_wr && (s_addr == 3'd3) && s_din[0];
    assign w_abort  = w_wr && (s_addr == 3'd3) && s_din[1];
    assign w_w1c    = w_wr && (s_addr == 3'd4);
    assign w_busy   = (r_state != ST_IDLE);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop    = w_rd && (s_addr == 3'd6) && !w_empty;
    assign w_count4 = 4'(r_count);
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_err   = 1'b0;
        w_set_abort = 1'b0;
        w_set_rej   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_full) w_set_rej   = 1'b1;
                    else        w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_abort) begin
                    w_set_abort = 1'b1;
                    w_state_nxt = ST_CLR;
                end else if (alu_op_done == 2'b11) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_CLR;
                end else if (alu_op_done != 2'b10) begin
                    // 01 is not a legal alu32 response; treat it like an invalid opcode
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || r_state != ST_EXEC) begin
            r_done_fb <= '0;
            r_res1_fb <= '0;
            r_res2_fb <= '0;
        end else begin
            r_done_fb <= alu_op_done;
            r_res1_fb <= alu_result1;
            r_res2_fb <= alu_result2;
        end
    end

    // alu32 reads the operands combinationally, so they are frozen while busy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_opcode <= '0;
            r_int_en <= 1'b0;
        end else begin
            if (w_wr && !w_busy) begin
                case (s_addr)
                    3'd0:    r_a      <= s_din;
                    3'd1:    r_b      <= s_din;
                    3'd2:    r_opcode <= s_din[3:0];
                    default: ;
                endcase
            end
            if (w_wr && s_addr == 3'd3) r_int_en <= s_din[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_op    <= 1'b0;
            r_aborted   <= 1'b0;
            r_start_rej <= 1'b0;
        end else begin
            r_err_op    <= w_set_err   | (r_err_op    & ~(w_w1c & s_din[7]));
            r_aborted   <= w_set_abort | (r_aborted   & ~(w_w1c & s_din[8]));
            r_start_rej <= w_set_rej   | (r_start_rej & ~(w_w1c & s_din[9]));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {alu_result2, alu_result1};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (s_addr)
            3'd0: w_rdata = r_a;
            3'd1: w_rdata = r_b;
            3'd2: w_rdata = {28'b0, r_opcode};
            3'd3: w_rdata = {29'b0, r_int_en, 2'b0};
            3'd4: w_rdata = {22'b0, r_start_rej, r_aborted, r_err_op, w_count4,
                             w_full, !w_empty, w_busy};
            3'd5: if (!w_empty) w_rdata = w_head[31:0];
            3'd6: if (!w_empty) w_rdata = w_head[63:32];
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)  r_dout <= '0;
        else if (w_rd) r_dout <= w_rdata;
    end

    assign s_dout         = r_dout;
    assign o_irq          = r_int_en & !w_empty;
    assign a              = r_a;
    assign b              = r_b;
    assign opcode         = r_opcode;
    assign op_start       = (r_state == ST_EXEC);
    assign op_clear       = (r_state == ST_CLR);
    assign op_done_before = r_done_fb;
    assign result1_before = r_res1_fb;
    assign result2_before = r_res2_fb;
endmodule

// File: tb/tb_alu32_ctrl.sv
// Scoreboarded bench for alu32_ctrl with a small behavioural alu32 stand-in
// (ADD single cycle, MUL four EXEC cycles, 1111 invalid).
module tb_alu32_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_sel = 1'b0, s_wr = 1'b0;
    logic [2:0]  s_addr = '0;
    logic [31:0] s_din = '0;
    logic [31:0] s_dout, a, b, result1_before, result2_before;
    logic        o_irq, op_start, op_clear;
    logic [3:0]  opcode;
    logic [1:0]  op_done_before;
    logic [1:0]  alu_op_done;
    logic [31:0] alu_result1, alu_result2;

    alu32_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(s_dout), .o_irq(o_irq), .a(a), .b(b), .opcode(opcode),
        .op_start(op_start), .op_clear(op_clear), .op_done_before(op_done_before),
        .result1_before(result1_before), .result2_before(result2_before),
        .alu_op_done(alu_op_done), .alu_result1(alu_result1), .alu_result2(alu_result2)
    );

    always #5 clk = ~clk;

    // alu32 stand-in
    logic [2:0]  mul_cnt = '0;
    logic [63:0] prod;
    always @(posedge clk) mul_cnt <= op_start ? mul_cnt + 3'd1 : 3'd0;
    always_comb begin
        alu_op_done = 2'b00;
        alu_result1 = '0;
        alu_result2 = '0;
        prod        = {32'b0, a} * {32'b0, b};
        if (op_start) begin
            case (opcode)
                4'b1011: begin
                    alu_op_done = 2'b11;
                    alu_result1 = a + b;
                end
                4'b1101: begin
                    if (mul_cnt >= 3'd3) begin
                        alu_op_done = 2'b11;
                        alu_result1 = prod[31:0];
                        alu_result2 = prod[63:32];
                    end else begin
                        alu_op_done = 2'b10;
                    end
                end
                default: alu_op_done = 2'b00;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // monitor: a read at edge k shows up on s_dout after k; compare at the next negedge
    logic rd_pend = 1'b0;
    always @(posedge clk) rd_pend <= s_sel && !s_wr;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got read data 0x%0h, expected no read", s_dout);
            end else begin
                e_mon = exp_q.pop_front();
                check(e_mon.name, 64'(s_dout), 64'(e_mon.val));
            end
        end
    end

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = addr; s_din = data;
        @(posedge clk); #1;
        s_sel = 1'b0; s_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = addr;
        @(posedge clk); #1;
        s_sel = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while ((op_start || op_clear) && cyc < 50);
    endtask

    task automatic run_add(input logic [31:0] x, input logic [31:0] y);
        int c;
        bus_write(3'd0, x);
        bus_write(3'd1, y);
        bus_write(3'd3, 32'h1);
        wait_idle(c);
        check("add_busy_cycles", 64'(c), 64'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, exec;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_start", 64'(op_start), 64'd0);
        check("rst_op_clear", 64'(op_clear), 64'd0);
        check("rst_irq", 64'(o_irq), 64'd0);
        check("rst_dout", 64'(s_dout), 64'd0);
        check("rst_fb", {30'b0, op_done_before, result1_before}, 64'd0);
        reset_n = 1'b1;
        bus_read(3'd4, 32'h0, "status_reset");

        // ADD 5+7
        bus_write(3'd0, 32'd5);
        bus_write(3'd1, 32'd7);
        bus_write(3'd2, 32'hB);
        bus_read(3'd0, 32'd5, "reg_a");
        bus_read(3'd2, 32'hB, "reg_opcode");
        bus_write(3'd3, 32'h1);
        check("add_op_start", 64'(op_start), 64'd1);
        wait_idle(c);
        check("add_busy_cycles", 64'(c), 64'd2);
        bus_read(3'd4, 32'h0A, "add_status");
        bus_read(3'd5, 32'd12, "add_res_lo");
        bus_read(3'd6, 32'd0, "add_res_hi");
        bus_read(3'd4, 32'h0, "add_status_popped");

        // MUL 0xFFFFFFFF * 2, with an A write attempted while busy
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd1, 32'd2);
        bus_write(3'd2, 32'hD);
        bus_write(3'd3, 32'h1);
        exec = 0;
        while (op_start && exec < 20) begin
            exec++;
            if (exec == 1) bus_write(3'd0, 32'h1234);
            else begin
                @(posedge clk); #1;
            end
        end
        check("mul_exec_cycles", 64'(exec), 64'd4);
        check("mul_op_clear", 64'(op_clear), 64'd1);
        check("mul_fb_done", 64'(op_done_before), 64'd3);
        check("mul_fb_res", {result2_before, result1_before}, 64'h1_FFFF_FFFE);
        @(posedge clk); #1;
        check("mul_clear_pulse", 64'(op_clear), 64'd0);
        check("mul_fb_zero", {result2_before, result1_before}, 64'd0);
        bus_read(3'd0, 32'hFFFF_FFFF, "busy_write_ignored");
        bus_read(3'd4, 32'h0A, "mul_status");
        bus_read(3'd5, 32'hFFFF_FFFE, "mul_res_lo");
        bus_read(3'd6, 32'h1, "mul_res_hi");

        // fill, reject, clear, drain across pointer wrap
        bus_write(3'd2, 32'hB);
        run_add(32'd1, 32'd1);
        run_add(32'd2, 32'd3);
        run_add(32'd10, 32'd20);
        run_add(32'd100, 32'd200);
        bus_read(3'd4, 32'h26, "full_status");
        bus_write(3'd3, 32'h1);
        check("rej_no_exec", 64'(op_start), 64'd0);
        bus_read(3'd4, 32'h226, "rej_status");
        bus_write(3'd4, 32'h200);
        bus_read(3'd4, 32'h26, "rej_cleared");
        bus_read(3'd5, 32'd2, "f0_lo");
        bus_read(3'd6, 32'd0, "f0_hi");
        bus_read(3'd5, 32'd5, "f1_lo");
        bus_read(3'd6, 32'd0, "f1_hi");
        run_add(32'd7, 32'd8);
        run_add(32'd1000, 32'd1);
        bus_read(3'd4, 32'h26, "refill_status");
        bus_read(3'd5, 32'd30, "f2_lo");
        bus_read(3'd6, 32'd0, "f2_hi");
        bus_read(3'd5, 32'd300, "f3_lo");
        bus_read(3'd6, 32'd0, "f3_hi");
        bus_read(3'd5, 32'd15, "wrap0_lo");
        bus_read(3'd6, 32'd0, "wrap0_hi");
        bus_read(3'd5, 32'd1001, "wrap1_lo");
        bus_read(3'd6, 32'd0, "wrap1_hi");
        bus_read(3'd4, 32'h0, "drained_status");
        bus_read(3'd6, 32'h0, "pop_empty");
        bus_read(3'd4, 32'h0, "pop_empty_status");

        // invalid opcode
        bus_write(3'd2, 32'hF);
        bus_write(3'd3, 32'h1);
        wait_idle(c);
        check("inv_busy_cycles", 64'(c), 64'd2);
        bus_read(3'd4, 32'h80, "err_op_status");
        bus_write(3'd4, 32'h80);
        bus_read(3'd4, 32'h0, "err_op_cleared");

        // ABORT on the third EXEC cycle of a MUL
        bus_write(3'd0, 32'd3);
        bus_write(3'd1, 32'd4);
        bus_write(3'd2, 32'hD);
        bus_write(3'd3, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_still_exec", 64'(op_start), 64'd1);
        bus_write(3'd3, 32'h2);
        check("abort_to_clr", {62'b0, op_start, op_clear}, 64'd1);
        @(posedge clk); #1;
        check("abort_fb_zero", {30'b0, op_done_before, result1_before}, 64'd0);
        check("abort_fb2_zero", 64'(result2_before), 64'd0);
        check("abort_idle", {62'b0, op_start, op_clear}, 64'd0);
        bus_read(3'd4, 32'h100, "aborted_status");
        bus_write(3'd4, 32'h100);

        // RES_HI pop on the same edge as a push
        bus_write(3'd2, 32'hB);
        run_add(32'd1, 32'd2);
        bus_read(3'd5, 32'd3, "pp_head_lo");
        bus_write(3'd0, 32'd10);
        bus_write(3'd1, 32'd5);
        bus_write(3'd3, 32'h1);
        bus_read(3'd6, 32'd0, "pp_pop_hi");
        bus_read(3'd4, 32'h0B, "pp_status_clr");
        bus_read(3'd4, 32'h0A, "pp_status_idle");
        bus_read(3'd5, 32'd15, "pp_new_lo");
        bus_read(3'd6, 32'd0, "pp_new_hi");
        bus_read(3'd4, 32'h0, "pp_empty");

        // interrupt, then reset in the middle of a MUL
        run_add(32'd20, 32'd22);
        check("irq_off", 64'(o_irq), 64'd0);
        bus_write(3'd3, 32'h4);
        check("irq_on", 64'(o_irq), 64'd1);
        bus_write(3'd0, 32'd6);
        bus_write(3'd1, 32'd7);
        bus_write(3'd2, 32'hD);
        bus_read(3'd3, 32'h4, "ctrl_read");
        bus_write(3'd3, 32'h5);
        @(posedge clk); #1;
        check("mid_exec", 64'(op_start), 64'd1);
        check("mid_fb_busy", 64'(op_done_before), 64'd2);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("mr_ctl", {60'b0, op_start, op_clear, o_irq, 1'b0}, 64'd0);
        check("mr_dout", 64'(s_dout), 64'd0);
        check("mr_ab", {a, b}, 64'd0);
        check("mr_opcode", 64'(opcode), 64'd0);
        check("mr_fb", {30'b0, op_done_before, result1_before}, 64'd0);
        check("mr_fb2", 64'(result2_before), 64'd0);
        bus_read(3'd4, 32'h0, "mr_status");
        bus_read(3'd3, 32'h0, "mr_ctrl");
        bus_read(3'd5, 32'h0, "mr_empty_lo");

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
